neuron_update_scheduler: RTL and testbench
==========================================

Name: neuron_update_scheduler

Overview:
Sequences one shared LIF accelerator datapath across NUM_NEURONS neurons for each timestep. On a timestep tick it walks neuron indices 0..NUM_NEURONS-1: fetches each neuron's state from neuron memory, drives the accelerator inputs, waits the accelerator latency, writes the new potential back and emits a spike event when the neuron fires. It sits between the neuron-state memory, the accelerator and the spike output queue of a NoC node.

Parameters:
NUM_NEURONS, 16, neurons served per timestep (>=1)
IDX_W, 4, neuron index width, clog2(NUM_NEURONS), minimum 1
ACC_LATENCY, 2, cycles from accelerator inputs stable to acc_spiked/acc_potential valid (>=1)

Ports:
CLK  input  1  clock, all state on rising edge
RESET  input  1  asynchronous, active-high reset
timestep_start  input  1  single-cycle request to process all neurons
busy  output  1  high from accepted start through DONE cycle
done  output  1  one-cycle pulse when last neuron is written back
mem_rd_en  output  1  neuron memory read strobe
mem_rd_addr  output  IDX_W  neuron index to read
mem_rd_spike_in  input  4  input spikes for neuron, valid 1 cycle after mem_rd_en
mem_rd_weight  input  128  four packed IEEE-754 single weights, same timing
mem_rd_threshold  input  32  IEEE-754 threshold, same timing
mem_rd_potential  input  32  IEEE-754 current potential, same timing
mem_rd_decay  input  3  decay rate, same timing
acc_spike_in  output  4  to accelerator
acc_weight  output  128  to accelerator
acc_v_threshold  output  32  to accelerator
acc_current_potential  output  32  to accelerator
acc_decay_rate  output  3  to accelerator
acc_spiked  input  1  accelerator spike result
acc_potential  input  32  accelerator potential_to_mem
mem_wr_en  output  1  potential writeback strobe
mem_wr_addr  output  IDX_W  writeback index
mem_wr_data  output  32  writeback potential
spike_valid  output  1  spike event valid
spike_id  output  IDX_W  index of neuron that fired
spike_ready  input  1  downstream accepts spike event

Behaviour:
- Reset: all outputs 0, state IDLE, index 0. Reset asserted mid-sweep aborts immediately; no writeback, no done, no spike for the partial neuron.
- States: IDLE, FETCH, LOAD, COMPUTE, WRITE, STALL, DONE.
- IDLE: timestep_start -> FETCH, index=0, busy=1 from next cycle. timestep_start while busy is ignored, not queued.
- FETCH (1 cycle): mem_rd_en=1, mem_rd_addr=index.
- LOAD (1 cycle): register all mem_rd_* into acc_* registers; acc_* hold stable until next LOAD.
- COMPUTE: ACC_LATENCY cycles counted by a down-counter, then WRITE.
- WRITE (1 cycle): mem_wr_en=1, mem_wr_addr=index, mem_wr_data=acc_potential. If acc_spiked, spike_valid=1, spike_id=index, also capture acc_spiked for STALL.
- Spike handshake: transfer when spike_valid && spike_ready. If not ready in WRITE -> STALL, holding spike_valid/spike_id (mem_wr_en 0 in STALL, writeback done once). Leave STALL on ready.
- After transfer or no spike: if index==NUM_NEURONS-1 -> DONE, else index+1 -> FETCH. No wrap past last index.
- DONE (1 cycle): done=1, busy=1; next cycle IDLE, busy=0.
- Per neuron, no stall: 3+ACC_LATENCY cycles. Sweep: NUM_NEURONS*(3+ACC_LATENCY)+1 cycles from start-accepted edge to done.
- No arithmetic on float data; values passed bit-exact.

Optional Feature:
SPIKE_COUNT_EN: adds output spike_count[15:0], cleared to 0 on reset and on accepted timestep_start, incremented on each spike handshake transfer, saturating at 16'hFFFF, held after done. Without macro the port and counter do not exist; all other behaviour identical.

Test Plan:
- Reset during COMPUTE of neuron 5 -> all outputs 0 next cycle, no mem_wr_en, no done; subsequent start sweeps from index 0.
- NUM_NEURONS=4, ACC_LATENCY=2, memory neuron 0 = {weight 0x3DCCCCCD_40000000_3F99999A_40400000, threshold 0x40E66666, potential 0x40800000, decay 1}, acc model returns spiked=0, potential 0x40400000 -> acc_* match memory bit-exact, mem_wr_addr 0 data 0x40400000, done after 21 cycles.
- acc model spikes for neurons 1 and 3, spike_ready=1 -> spike_valid pulses with spike_id 1 then 3, exactly 2 events, 4 writebacks.
- Neuron 2 spikes, spike_ready low 5 cycles -> STALL 5 cycles, spike_id=2 held, single writeback for neuron 2, done delayed by 5.
- timestep_start pulsed while busy -> ignored, exactly one sweep, one done.
- SPIKE_COUNT_EN defined, 3 spikes in sweep -> spike_count=3 after done; next start clears to 0.

Source files
------------

// File: rtl/neuron_update_scheduler.sv
// neuron_update_scheduler: sweeps all neurons through one shared LIF accelerator per timestep.
// Define SPIKE_COUNT_EN to add a saturating spike_count output for the current sweep.
module neuron_update_scheduler #(
    parameter int NUM_NEURONS = 16,
    parameter int IDX_W       = 4,
    parameter int ACC_LATENCY = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               timestep_start,
    output logic               busy,
    output logic               done,
    output logic               mem_rd_en,
    output logic [IDX_W-1:0]   mem_rd_addr,
    input  logic [3:0]         mem_rd_spike_in,
    input  logic [127:0]       mem_rd_weight,
    input  logic [31:0]        mem_rd_threshold,
    input  logic [31:0]        mem_rd_potential,
    input  logic [2:0]         mem_rd_decay,
    output logic [3:0]         acc_spike_in,
    output logic [127:0]       acc_weight,
    output logic [31:0]        acc_v_threshold,
    output logic [31:0]        acc_current_potential,
    output logic [2:0]         acc_decay_rate,
    input  logic               acc_spiked,
    input  logic [31:0]        acc_potential,
    output logic               mem_wr_en,
    output logic [IDX_W-1:0]   mem_wr_addr,
    output logic [31:0]        mem_wr_data,
    output logic               spike_valid,
    output logic [IDX_W-1:0]   spike_id,
`ifdef SPIKE_COUNT_EN
    output logic [15:0]        spike_count,
`endif
    input  logic               spike_ready
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, COMPUTE, WRITE, STALL, DONE} state_t;

    localparam int CNT_W = ACC_LATENCY > 1 ? $clog2(ACC_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACC_LATENCY - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_t             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               rd_en_q;
    logic [IDX_W-1:0]   rd_addr_q;
    logic [3:0]         acc_spike_q;
    logic [127:0]       acc_weight_q;
    logic [31:0]        acc_thr_q;
    logic [31:0]        acc_pot_q;
    logic [2:0]         acc_decay_q;
    logic               wr_en_q;
    logic [IDX_W-1:0]   wr_addr_q;
    logic [31:0]        wr_data_q;
    logic               spk_valid_q;
    logic [IDX_W-1:0]   spk_id_q;
    logic               last;

    assign last = idx_q == LAST_IDX;

    assign busy                  = busy_q;
    assign done                  = done_q;
    assign mem_rd_en             = rd_en_q;
    assign mem_rd_addr           = rd_addr_q;
    assign acc_spike_in          = acc_spike_q;
    assign acc_weight            = acc_weight_q;
    assign acc_v_threshold       = acc_thr_q;
    assign acc_current_potential = acc_pot_q;
    assign acc_decay_rate        = acc_decay_q;
    assign mem_wr_en             = wr_en_q;
    assign mem_wr_addr           = wr_addr_q;
    assign mem_wr_data           = wr_data_q;
    assign spike_valid           = spk_valid_q;
    assign spike_id              = spk_id_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            acc_spike_q  <= '0;
            acc_weight_q <= '0;
            acc_thr_q    <= '0;
            acc_pot_q    <= '0;
            acc_decay_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            spk_valid_q  <= 1'b0;
            spk_id_q     <= '0;
        end else begin
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: if (timestep_start) begin
                    state_q   <= FETCH;
                    busy_q    <= 1'b1;
                    idx_q     <= '0;
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= '0;
                end
                FETCH: state_q <= LOAD;
                LOAD: begin
                    acc_spike_q  <= mem_rd_spike_in;
                    acc_weight_q <= mem_rd_weight;
                    acc_thr_q    <= mem_rd_threshold;
                    acc_pot_q    <= mem_rd_potential;
                    acc_decay_q  <= mem_rd_decay;
                    cnt_q        <= CNT_INIT;
                    state_q      <= COMPUTE;
                end
                // accelerator result is sampled on the edge that ends the last COMPUTE cycle
                COMPUTE: if (cnt_q == '0) begin
                    state_q     <= WRITE;
                    wr_en_q     <= 1'b1;
                    wr_addr_q   <= idx_q;
                    wr_data_q   <= acc_potential;
                    spk_valid_q <= acc_spiked;
                    spk_id_q    <= acc_spiked ? idx_q : '0;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
                WRITE, STALL: if (spk_valid_q && !spike_ready) begin
                    state_q <= STALL;
                end else begin
                    spk_valid_q <= 1'b0;
                    spk_id_q    <= '0;
                    if (last) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        idx_q     <= idx_q + 1'b1;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= idx_q + 1'b1;
                        state_q   <= FETCH;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SPIKE_COUNT_EN
    logic [15:0] count_q;
    assign spike_count = count_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            count_q <= '0;
        else if (state_q == IDLE && timestep_start)
            count_q <= '0;
        else if (spk_valid_q && spike_ready && count_q != 16'hFFFF)
            count_q <= count_q + 1'b1;
    end
`endif

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// tb_neuron_update_scheduler: scoreboard bench; directed sweeps against a memory and accelerator model.
module tb_neuron_update_scheduler;
    localparam int N  = 4;
    localparam int IW = 2;
    localparam int L  = 2;

    logic           CLK = 1'b0;
    logic           RESET = 1'b1;
    logic           timestep_start = 1'b0;
    logic           busy, done, mem_rd_en, mem_wr_en, spike_valid;
    logic [IW-1:0]  mem_rd_addr, mem_wr_addr, spike_id;
    logic [3:0]     mem_rd_spike_in, acc_spike_in;
    logic [127:0]   mem_rd_weight, acc_weight;
    logic [31:0]    mem_rd_threshold, mem_rd_potential, acc_v_threshold, acc_current_potential;
    logic [2:0]     mem_rd_decay, acc_decay_rate;
    logic           acc_spiked;
    logic [31:0]    acc_potential, mem_wr_data;
    logic           spike_ready = 1'b1;
`ifdef SPIKE_COUNT_EN
    logic [15:0]    spike_count;
`endif

    neuron_update_scheduler #(.NUM_NEURONS(N), .IDX_W(IW), .ACC_LATENCY(L)) dut (
        .CLK(CLK), .RESET(RESET), .timestep_start(timestep_start), .busy(busy), .done(done),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_spike_in(mem_rd_spike_in),
        .mem_rd_weight(mem_rd_weight), .mem_rd_threshold(mem_rd_threshold),
        .mem_rd_potential(mem_rd_potential), .mem_rd_decay(mem_rd_decay),
        .acc_spike_in(acc_spike_in), .acc_weight(acc_weight), .acc_v_threshold(acc_v_threshold),
        .acc_current_potential(acc_current_potential), .acc_decay_rate(acc_decay_rate),
        .acc_spiked(acc_spiked), .acc_potential(acc_potential),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .spike_valid(spike_valid), .spike_id(spike_id),
`ifdef SPIKE_COUNT_EN
        .spike_count(spike_count),
`endif
        .spike_ready(spike_ready)
    );

    always #5 CLK = ~CLK;

    logic [3:0]   m_spk [N];
    logic [127:0] m_w   [N];
    logic [31:0]  m_thr [N];
    logic [31:0]  m_pot [N];
    logic [2:0]   m_dec [N];
    logic [31:0]  exp_pot [N];

    // read data is valid only in the cycle after mem_rd_en; otherwise garbage
    always @(posedge CLK) begin
        if (mem_rd_en) begin
            mem_rd_spike_in  <= m_spk[mem_rd_addr];
            mem_rd_weight    <= m_w[mem_rd_addr];
            mem_rd_threshold <= m_thr[mem_rd_addr];
            mem_rd_potential <= m_pot[mem_rd_addr];
            mem_rd_decay     <= m_dec[mem_rd_addr];
        end else begin
            mem_rd_spike_in  <= 4'hF;
            mem_rd_weight    <= {4{32'hDEADBEEF}};
            mem_rd_threshold <= 32'hDEADBEEF;
            mem_rd_potential <= 32'hDEADBEEF;
            mem_rd_decay     <= 3'h5;
        end
    end

    // accelerator: potential - 0x00400000, fires when spike_in[3]; valid 2 cycles after inputs
    always @(posedge CLK) begin
        acc_potential <= acc_current_potential - 32'h0040_0000;
        acc_spiked    <= acc_spike_in[3];
    end

    int n_tests = 0, n_fail = 0;
    int done_cnt = 0, wr_cnt = 0, spk_cnt = 0;
    logic [IW+31:0] wr_q  [$];
    logic [198:0]   acc_q [$];
    logic [IW-1:0]  spk_q [$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (done) done_cnt++;
        if (mem_wr_en) begin
            wr_cnt++;
            if (wr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_wr: got addr %0d data %h expected no writeback", mem_wr_addr, mem_wr_data);
            end else begin
                chk("wr_addr_data", {mem_wr_addr, mem_wr_data}, wr_q.pop_front());
                chk("acc_bits", {acc_spike_in, acc_weight, acc_v_threshold, acc_current_potential, acc_decay_rate}, acc_q.pop_front());
            end
        end
        if (spike_valid && spike_ready) begin
            spk_cnt++;
            if (spk_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_spike: got id %0d expected no spike", spike_id);
            end else begin
                chk("spike_id", spike_id, spk_q.pop_front());
            end
        end
    end

    task automatic push_sweep();
        for (int i = 0; i < N; i++) begin
            wr_q.push_back({IW'(i), exp_pot[i]});
            acc_q.push_back({m_spk[i], m_w[i], m_thr[i], m_pot[i], m_dec[i]});
            if (m_spk[i][3]) spk_q.push_back(IW'(i));
        end
    endtask

    task automatic run_sweep(input int exp_cyc, input string nm);
        int cyc;
        push_sweep();
        @(negedge CLK);
        timestep_start = 1'b1;
        @(posedge CLK);
        cyc = 1;
        @(negedge CLK);
        timestep_start = 1'b0;
        chk({nm, "_busy"}, busy, 1'b1);
        while (!done && cyc < 300) begin
            @(posedge CLK);
            cyc++;
            @(negedge CLK);
        end
        chk({nm, "_cycles"}, cyc, exp_cyc);
        @(negedge CLK);
        chk({nm, "_busy_after"}, busy, 1'b0);
        chk({nm, "_queues_drained"}, wr_q.size() + spk_q.size(), 0);
    endtask

    task automatic set_spikes(input logic [3:0] s0, input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3);
        m_spk[0] = s0; m_spk[1] = s1; m_spk[2] = s2; m_spk[3] = s3;
    endtask

    initial begin
        int d0, w0, s0, k;
        m_w[0] = 128'h3DCCCCCD_40000000_3F99999A_40400000; m_thr[0] = 32'h40E66666; m_pot[0] = 32'h40800000; m_dec[0] = 3'd1; exp_pot[0] = 32'h40400000;
        m_w[1] = 128'h3F800000_3F000000_3E800000_3E000000; m_thr[1] = 32'h3F800000; m_pot[1] = 32'h41000000; m_dec[1] = 3'd2; exp_pot[1] = 32'h40C00000;
        m_w[2] = 128'h40A00000_40C00000_40E00000_41000000; m_thr[2] = 32'h41200000; m_pot[2] = 32'h3F800000; m_dec[2] = 3'd3; exp_pot[2] = 32'h3F400000;
        m_w[3] = 128'hBF800000_C0000000_C0400000_C0800000; m_thr[3] = 32'h42000000; m_pot[3] = 32'h42C80000; m_dec[3] = 3'd7; exp_pot[3] = 32'h42880000;

        repeat (3) @(negedge CLK);
        chk("rst_ctrl", {busy, done, mem_rd_en, mem_wr_en, spike_valid}, 5'b0);
        chk("rst_addr", {mem_rd_addr, mem_wr_addr, spike_id, mem_wr_data}, '0);
        chk("rst_acc", {acc_spike_in, acc_weight, acc_v_threshold, acc_current_potential, acc_decay_rate}, '0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        // no spikes: bit-exact passthrough and 21-cycle sweep
        set_spikes(4'h1, 4'h2, 4'h4, 4'h5);
        w0 = wr_cnt; s0 = spk_cnt;
        run_sweep(21, "plain");
        chk("plain_wr_count", wr_cnt - w0, 4);
        chk("plain_spike_count", spk_cnt - s0, 0);

        // neurons 1 and 3 fire, downstream always ready
        set_spikes(4'h1, 4'h9, 4'h2, 4'h8);
        w0 = wr_cnt; s0 = spk_cnt;
        run_sweep(21, "spk13");
        chk("spk13_events", spk_cnt - s0, 2);
        chk("spk13_wr_count", wr_cnt - w0, 4);

        // neuron 2 fires, ready held low for 5 cycles
        set_spikes(4'h0, 4'h0, 4'h8, 4'h0);
        w0 = wr_cnt;
        spike_ready = 1'b0;
        fork
            run_sweep(26, "stall");
            begin
                k = 0;
                while (!spike_valid && k < 100) begin
                    @(negedge CLK);
                    k++;
                end
                chk("stall_first_id", {spike_valid, spike_id}, {1'b1, 2'd2});
                for (int i = 0; i < 4; i++) begin
                    @(negedge CLK);
                    chk("stall_hold", {spike_valid, spike_id, mem_wr_en}, {1'b1, 2'd2, 1'b0});
                end
                @(posedge CLK);
                #1 spike_ready = 1'b1;
            end
        join
        chk("stall_wr_count", wr_cnt - w0, 4);

        // start pulsed while busy must be ignored
        set_spikes(4'h0, 4'h0, 4'h0, 4'h0);
        d0 = done_cnt; w0 = wr_cnt;
        fork
            run_sweep(21, "busy_start");
            begin
                repeat (7) @(negedge CLK);
                timestep_start = 1'b1;
                @(negedge CLK);
                timestep_start = 1'b0;
            end
        join
        repeat (30) @(negedge CLK);
        chk("busy_start_done_count", done_cnt - d0, 1);
        chk("busy_start_wr_count", wr_cnt - w0, 4);

        // reset during COMPUTE of neuron 2 aborts the sweep
        d0 = done_cnt;
        push_sweep();
        @(negedge CLK);
        timestep_start = 1'b1;
        @(negedge CLK);
        timestep_start = 1'b0;
        k = 0;
        while (!(mem_wr_en && mem_wr_addr == 2'd1) && k < 100) begin
            @(negedge CLK);
            k++;
        end
        repeat (3) @(negedge CLK);
        chk("pre_reset_state", {busy, acc_current_potential}, {1'b1, m_pot[2]});
        RESET = 1'b1;
        #1;
        chk("mid_rst_ctrl", {busy, done, mem_rd_en, mem_wr_en, spike_valid}, 5'b0);
        chk("mid_rst_acc", {acc_weight, acc_current_potential}, '0);
        repeat (2) @(negedge CLK);
        chk("mid_rst_pending_wr", wr_q.size(), 2);
        chk("mid_rst_no_done", done_cnt - d0, 0);
        wr_q.delete();
        acc_q.delete();
        spk_q.delete();
        RESET = 1'b0;
        repeat (2) @(negedge CLK);
        run_sweep(21, "after_rst");

`ifdef SPIKE_COUNT_EN
        set_spikes(4'h8, 4'h8, 4'h0, 4'h8);
        run_sweep(21, "count");
        chk("spike_count_after_done", spike_count, 16'd3);
        set_spikes(4'h0, 4'h0, 4'h0, 4'h0);
        push_sweep();
        @(negedge CLK);
        timestep_start = 1'b1;
        @(negedge CLK);
        timestep_start = 1'b0;
        chk("spike_count_cleared", spike_count, 16'd0);
        k = 0;
        while (!done && k < 100) begin
            @(negedge CLK);
            k++;
        end
        chk("count_sweep_done", done, 1'b1);
`endif

        repeat (3) @(negedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
